fnd_scan_display: RTL



---
 rtl/fnd_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 93 +++++++++
 rtl/fnd_scan_display.sv | 97 +++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fnd_pkg
// Brief   : Shared types and constants for the 4-digit seven-segment display.
// Revision: 1.0 - initial release
// ============================================================================
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  localparam int BCD_DIGITS  = 5;
  localparam int BIN_WIDTH   = 16;
  localparam int SHIFT_WIDTH = BIN_WIDTH + 4 * BCD_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns, entry n is digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    if (digit <= 4'd9) begin
      pattern = SEG_TABLE[digit];
    end
    return pattern;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential shift-add-3 binary-to-BCD converter, 18-cycle period.
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        busy,
  output logic        done
);

  conv_state_t state;
  conv_state_t state_nxt;

  logic [SHIFT_WIDTH-1:0] shreg;
  logic [SHIFT_WIDTH-1:0] shreg_nxt;
  logic [SHIFT_WIDTH-1:0] adjusted;
  logic [3:0]             bit_cnt;
  logic [3:0]             bit_cnt_nxt;
  logic                   busy_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
      localparam int LSB = BIN_WIDTH + 4 * gi;
      assign adjusted[LSB +: 4] = (shreg[LSB +: 4] >= 4'd5) ?
                                  shreg[LSB +: 4] + 4'd3 : shreg[LSB +: 4];
    end
  endgenerate

  assign adjusted[BIN_WIDTH-1:0] = shreg[BIN_WIDTH-1:0];

  // BCD field is only meaningful while done is high (state LATCH).
  assign bcd  = shreg[SHIFT_WIDTH-1 -: 4*BCD_DIGITS];
  assign done = (state == LATCH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    busy_nxt    = busy;
    unique case (state)
      IDLE: begin
        shreg_nxt   = {{(4*BCD_DIGITS){1'b0}}, bin};
        bit_cnt_nxt = 4'd0;
        busy_nxt    = 1'b1;
        state_nxt   = CONV;
      end
      CONV: begin
        shreg_nxt   = {adjusted[SHIFT_WIDTH-2:0], 1'b0};
        bit_cnt_nxt = bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fnd_scan_display.sv
`default_nettype none
// ============================================================================
// Module  : fnd_scan_display
// Brief   : Decimal display of a 16-bit count on a multiplexed 4-digit display.
// Revision: 1.0 - initial release
// ============================================================================
module fnd_scan_display
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [19:0]   conv_bcd;
  logic          conv_done;
  logic [15:0]   disp_bcd;
  logic          overflow;
  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [3:0]    lead_zero;
  logic [3:0]    digit_cur;
  logic          blank_cur;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic          dp_nxt;

  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst  (rst),
    .bin  (value),
    .bcd  (conv_bcd),
    .busy (busy),
    .done (conv_done)
  );

  // Display register only moves on a finished conversion, never mid-shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_bcd <= '0;
      overflow <= 1'b0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd[15:0];
      overflow <= |conv_bcd[19:16];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler <= '0;
      digit_idx <= 2'd0;
    end else if (prescaler == PW'(SCAN_DIV - 1)) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (disp_bcd[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_bcd[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_bcd[7:4] == 4'd0);
  end

  always_comb begin
    digit_cur = disp_bcd[{digit_idx, 2'b00} +: 4];
    blank_cur = BLANK_LZ && lead_zero[digit_idx];
    seg_nxt   = blank_cur ? SEG_BLANK : seg_encode(digit_cur);
    an_nxt    = ~(4'b0001 << digit_idx);
    dp_nxt    = ~(overflow && (digit_idx == 2'd0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule
`default_nettype wire
